// File: rtl/pipelined_rcla_adder.sv
// Pipelined ripple-block carry look-ahead adder.
// S = Y + zext(X) + CIN (add) or Y - zext(X) (subtract); S[YW] = carry / no-borrow.
// The word is cut into NSTAGE slices of SW bits. Slice k is summed in stage k
// from 4-bit RCLA blocks with 4-block group look-ahead; operand bits of higher
// slices travel in skew registers and finished low slices travel in deskew
// registers, so S leaves the last stage word-aligned.
module pipelined_rcla_adder #(
  parameter int XW     = 16,
  parameter int YW     = 64,
  parameter int NSTAGE = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [XW-1:0] X,
  input  logic [YW-1:0] Y,
  input  logic          CIN,
  input  logic          SUB,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [YW:0]   S
);

  localparam int SW = YW / NSTAGE;   // bits per slice
  localparam int NB = SW / 4;        // 4-bit blocks per slice
  localparam int NG = (NB + 3) / 4;  // look-ahead groups per slice (last may be partial)

  if (XW < 1 || XW > YW) begin : g_bad_xw
    $error("pipelined_rcla_adder: XW must satisfy 1 <= XW <= YW");
  end
  if ((YW % NSTAGE) != 0 || SW == 0 || (SW % 4) != 0) begin : g_bad_sw
    $error("pipelined_rcla_adder: YW/NSTAGE must be a non-zero multiple of 4");
  end

  // Block generate/propagate of a 4-bit RCLA block: {G, P}.
  function automatic logic [1:0] rcla4_gp(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] g;
    logic [3:0] p;
    g = a & b;
    p = a ^ b;
    return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
  endfunction

  // Sum bits of a 4-bit RCLA block with look-ahead internal carries.
  function automatic logic [3:0] rcla4_sum(input logic [3:0] a, input logic [3:0] b,
                                           input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return p ^ c;
  endfunction

  // Look-ahead carry into block q (1..4) of a group from the block G/P terms.
  function automatic logic grp_carry(input int q, input logic [3:0] bg, input logic [3:0] bp,
                                     input logic ci);
    logic c;
    case (q)
      1:       c = bg[0] | (bp[0] & ci);
      2:       c = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & ci);
      3:       c = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                 | (bp[2] & bp[1] & bp[0] & ci);
      default: c = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
                 | (bp[3] & bp[2] & bp[1] & bg[0]) | (bp[3] & bp[2] & bp[1] & bp[0] & ci);
    endcase
    return c;
  endfunction

  // One slice: groups of look-ahead blocks, group carries ripple. Returns {cout, sum}.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                            input logic ci);
    logic [4*NG-1:0] bg;
    logic [4*NG-1:0] bp;
    logic [NB:0]     bc;
    logic [SW-1:0]   s;
    logic [1:0]      gp;
    int              idx;
    bg    = '0;
    bp    = '0;
    bc    = '0;
    s     = '0;
    bc[0] = ci;
    for (int j = 0; j < NB; j++) begin
      gp    = rcla4_gp(a[4*j +: 4], b[4*j +: 4]);
      bg[j] = gp[1];
      bp[j] = gp[0];
    end
    for (int grp = 0; grp < NG; grp++) begin
      for (int q = 1; q <= 4; q++) begin
        idx = 4*grp + q;
        if (idx <= NB) begin
          bc[idx] = grp_carry(q, bg[4*grp +: 4], bp[4*grp +: 4], bc[4*grp]);
        end
      end
    end
    for (int j = 0; j < NB; j++) begin
      s[4*j +: 4] = rcla4_sum(a[4*j +: 4], b[4*j +: 4], bc[j]);
    end
    return {bc[NB], s};
  endfunction

  logic [YW-1:0]     z_ext;
  logic [YW-1:0]     b_in;
  logic              c_in;
  logic [NSTAGE-1:0] rdy;
  logic [NSTAGE-1:0] vld_q;

  // Operand formation: zero-extend X, invert it and force carry-in for subtract.
  always_comb begin
    z_ext = YW'(X);
    b_in  = SUB ? ~z_ext : z_ext;
    c_in  = SUB | CIN;
  end

  // Stage k may advance when any stage at or above it is empty or the output is taken.
  always_comb begin
    logic full_above;
    rdy = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      full_above = 1'b1;
      for (int j = k; j < NSTAGE; j++) begin
        full_above = full_above & vld_q[j];
      end
      rdy[k] = OUT_READY | ~full_above;
    end
  end

  // Valid bits move with their data; a stalled stage keeps its bit.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vld_q <= '0;
    end else begin
      if (rdy[0]) vld_q[0] <= IN_VALID;
      for (int k = 1; k < NSTAGE; k++) begin
        if (rdy[k]) vld_q[k] <= vld_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int RW = (k + 1) * SW;       // result bits held after this stage
    localparam int IW = (NSTAGE - k) * SW;  // operand bits still to be summed

    logic [IW-1:0] in_a;
    logic [IW-1:0] in_b;
    logic          in_c;
    logic [SW:0]   sl;
    logic [RW-1:0] r_d;
    logic [RW-1:0] r_q;
    logic          c_q;

    if (k == 0) begin : g_src
      assign in_a = Y;
      assign in_b = b_in;
      assign in_c = c_in;
      assign r_d  = sl[SW-1:0];
    end else begin : g_src
      assign in_a = g_stage[k-1].g_ops.a_q;
      assign in_b = g_stage[k-1].g_ops.b_q;
      assign in_c = g_stage[k-1].c_q;
      assign r_d  = {sl[SW-1:0], g_stage[k-1].r_q};
    end

    assign sl = slice_add(in_a[SW-1:0], in_b[SW-1:0], in_c);

    // ---- stage k boundary: deskewed result bits and slice carry-out ----
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        r_q <= '0;
        c_q <= 1'b0;
      end else if (rdy[k]) begin
        r_q <= r_d;
        c_q <= sl[SW];
      end
    end

    if (k < NSTAGE - 1) begin : g_ops
      logic [IW-SW-1:0] a_q;
      logic [IW-SW-1:0] b_q;

      // Skew registers: operand bits of the slices not yet summed.
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy[k]) begin
          a_q <= in_a[IW-1:SW];
          b_q <= in_b[IW-1:SW];
        end
      end
    end
  end

  assign IN_READY  = rdy[0];
  assign OUT_VALID = vld_q[NSTAGE-1];
  assign S         = {g_stage[NSTAGE-1].c_q, g_stage[NSTAGE-1].r_q};

endmodule

// File: tb/tb_pipelined_rcla_adder.sv
// Bench for pipelined_rcla_adder: directed corner vectors, random streaming,
// back-pressure, random handshakes and mid-stream reset against an arithmetic model.
module tb_pipelined_rcla_adder;

  localparam int XW     = 16;
  localparam int YW     = 64;
  localparam int NSTAGE = 4;
  localparam int SWD    = YW + 1;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          IN_VALID;
  logic          IN_READY;
  logic [XW-1:0] X;
  logic [YW-1:0] Y;
  logic          CIN;
  logic          SUB;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [YW:0]   S;

  pipelined_rcla_adder #(.XW(XW), .YW(YW), .NSTAGE(NSTAGE)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .X(X), .Y(Y), .CIN(CIN), .SUB(SUB),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .S(S)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [YW:0] s;
    int          c;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          mon_en  = 1'b0;
  bit          chk_lat = 1'b0;
  bit          prev_hold = 1'b0;
  logic [YW:0] prev_s;
  exp_t        q[$];

  task automatic check_eq(input string tag, input logic [YW:0] got, input logic [YW:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer add, or Y - X with the no-borrow flag Y >= X.
  function automatic logic [YW:0] ref_sum(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                          input logic cin, input logic sub);
    logic [YW-1:0] z;
    z = YW'(x);
    if (sub) return {(y >= z), y - z};
    return {1'b0, y} + {1'b0, z} + SWD'(cin);
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: in-order results, latency, ready prediction and output hold.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (!RST_N) begin
        q.delete();
        prev_hold = 1'b0;
      end else begin
        exp_t e;
        if (prev_hold) begin
          check_eq("hold_valid", SWD'(OUT_VALID), SWD'(1));
          check_eq("hold_s", S, prev_s);
        end
        check_eq("in_ready", SWD'(IN_READY), SWD'(OUT_READY || (q.size() < NSTAGE)));
        if (OUT_VALID && OUT_READY) begin
          if (q.size() == 0) begin
            check_eq("spurious_out", SWD'(OUT_VALID), SWD'(0));
          end else begin
            e = q.pop_front();
            check_eq("result", S, e.s);
            if (chk_lat) check_eq("latency", SWD'(cyc - e.c), SWD'(NSTAGE));
          end
        end
        if (IN_VALID && IN_READY) q.push_back('{s: ref_sum(X, Y, CIN, SUB), c: cyc});
        prev_hold = OUT_VALID && !OUT_READY;
        prev_s    = S;
      end
    end
  end

  task automatic rand_ops();
    X   = ($urandom_range(0, 3) == 0) ? '1 : XW'($urandom);
    Y   = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
    CIN = 1'($urandom);
    SUB = 1'($urandom);
  endtask

  task automatic run_vec(input string tag, input logic [XW-1:0] x, input logic [YW-1:0] y,
                         input logic cin, input logic sub, input logic [YW:0] exp);
    int n;
    @(posedge CLK); #1;
    X = x; Y = y; CIN = cin; SUB = sub; IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    n = 1;
    while (!OUT_VALID && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    check_eq({tag, "_lat"}, SWD'(n), SWD'(NSTAGE));
    check_eq(tag, S, exp);
  endtask

  task automatic drain(input int ncyc);
    @(posedge CLK); #1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    repeat (ncyc) @(posedge CLK);
    #1;
  endtask

  initial begin
    int acc;
    RST_N = 1'b0; IN_VALID = 1'b0; X = '0; Y = '0; CIN = 1'b0; SUB = 1'b0; OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_out_valid", SWD'(OUT_VALID), SWD'(0));
    check_eq("rst_s", S, '0);
    @(posedge CLK); #1;
    RST_N   = 1'b1;
    mon_en  = 1'b1;
    chk_lat = 1'b1;
    @(negedge CLK);
    check_eq("rst_in_ready", SWD'(IN_READY), SWD'(1));

    run_vec("add_slice",  16'hFFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 65'h0_0000_0000_0001_0000);
    run_vec("ripple",     16'hFFFF, 64'hFFFF_FFFF_FFFF_0001, 1'b0, 1'b0, 65'h1_0000_0000_0000_0000);
    run_vec("ripple_cin", 16'hFFFF, 64'hFFFF_FFFF_FFFF_0001, 1'b1, 1'b0, 65'h1_0000_0000_0000_0001);
    run_vec("sub_borrow", 16'd1,    64'd0,   1'b0, 1'b1, 65'h0_FFFF_FFFF_FFFF_FFFF);
    run_vec("sub_brw_ci", 16'd1,    64'd0,   1'b1, 1'b1, 65'h0_FFFF_FFFF_FFFF_FFFF);
    run_vec("sub_eq",     16'd100,  64'd100, 1'b0, 1'b1, 65'h1_0000_0000_0000_0000);
    run_vec("sub_eq_ci",  16'd100,  64'd100, 1'b1, 1'b1, 65'h1_0000_0000_0000_0000);
    drain(4);

    // Back-to-back streaming, never stalled.
    for (int i = 0; i < 1000; i++) begin
      @(posedge CLK); #1;
      rand_ops();
      IN_VALID  = 1'b1;
      OUT_READY = 1'b1;
    end
    drain(8);

    // Back-pressure: fill the pipe, then pop and push in one cycle.
    chk_lat   = 1'b0;
    OUT_READY = 1'b0;
    acc       = 0;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      IN_VALID = 1'b1;
      @(negedge CLK);
      if (IN_VALID && IN_READY) acc++;
      @(posedge CLK); #1;
    end
    check_eq("bp_accepted", SWD'(acc), SWD'(NSTAGE));
    check_eq("bp_in_ready", SWD'(IN_READY), SWD'(0));
    check_eq("bp_out_valid", SWD'(OUT_VALID), SWD'(1));
    rand_ops();
    OUT_READY = 1'b1;
    @(negedge CLK);
    check_eq("popush_ready", SWD'(IN_READY), SWD'(1));
    @(posedge CLK); #1;
    rand_ops();
    OUT_READY = 1'b0;
    @(negedge CLK);
    check_eq("popush_full", SWD'(IN_READY), SWD'(0));
    drain(8);

    // Random handshakes on both sides.
    for (int i = 0; i < 1500; i++) begin
      @(posedge CLK); #1;
      rand_ops();
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
    end
    drain(10);
    @(negedge CLK);
    check_eq("no_loss", SWD'(q.size()), SWD'(0));

    // Reset with three results in flight.
    chk_lat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      rand_ops();
      IN_VALID  = 1'b1;
      OUT_READY = 1'b1;
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    RST_N    = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    check_eq("mid_rst_valid", SWD'(OUT_VALID), SWD'(0));
    check_eq("mid_rst_s", S, '0);
    check_eq("mid_rst_ready", SWD'(IN_READY), SWD'(1));
    run_vec("post_rst", 16'h1234, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 65'h0_0000_0000_0000_1235);
    drain(10);
    @(negedge CLK);
    check_eq("post_rst_empty", SWD'(q.size()), SWD'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
